// File: rtl/vid_mem_arbiter.sv
// Shares one memory port between display refresh fetches (priority) and CPU accesses.
// Optional VIDARB_STARVE_GUARD_EN: a waiting CPU goes next after 4 back-to-back video grants.
module vid_mem_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int FRAME_WORDS = 153600
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vid_req,
  input  logic              vid_frame,
  output logic [31:0]       vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_wdata,
  output logic              vid_ovr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  localparam logic [17:0] OFF_LAST = 18'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, VID, CPU, DONE} state_t;

  state_t            state;
  logic [17:0]       offset;
  logic [ADDR_W-1:0] fb_base;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_pend;
  logic              starve;
  logic              take_vid;
  logic              take_cpu;
  logic              vid_ack;

`ifdef VIDARB_STARVE_GUARD_EN
  // Counts video grants made while the CPU was already waiting; saturates at 4.
  logic [2:0] starve_cnt;
  assign starve = (starve_cnt == 3'd4);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         starve_cnt <= '0;
    else if (take_cpu) starve_cnt <= '0;
    else if (take_vid) starve_cnt <= cpu_req ? starve_cnt + 3'd1 : 3'd0;
  end
`else
  assign starve = 1'b0;
`endif

  assign take_vid = (state == IDLE) && vid_pend && !(starve && cpu_req);
  assign take_cpu = (state == IDLE) && cpu_req && (!vid_pend || starve);
  assign vid_ack  = (state == VID) && mem_ack;

  // Memory port decoded from state; video address frozen at grant so it is stable in VID.
  assign mem_req   = (state == VID) || (state == CPU);
  assign mem_we    = (state == CPU) && cpu_we;
  assign mem_addr  = (state == CPU) ? cpu_addr  : vid_addr;
  assign mem_wdata = (state == CPU) ? cpu_wdata : 32'h0;
  assign mem_be    = (state == CPU) ? cpu_be    : 4'hF;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      offset   <= '0;
      fb_base  <= '0;
      vid_pend <= 1'b0;
      vid_ovr  <= 1'b0;
    end else begin
      if (vid_frame)    offset <= '0;
      else if (vid_ack) offset <= (offset == OFF_LAST) ? 18'd0 : offset + 18'd1;

      if (vid_frame)     vid_pend <= 1'b0;
      else if (vid_req)  vid_pend <= 1'b1;
      else if (take_vid) vid_pend <= 1'b0;

      // A request landing on an unserved one is lost; report it until software clears it.
      if (vid_req && vid_pend && !take_vid) vid_ovr <= 1'b1;
      else if (cfg_we)                       vid_ovr <= 1'b0;

      if (cfg_we) fb_base <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      vid_addr  <= '0;
      vid_data  <= '0;
      vid_valid <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (take_vid) begin
            state    <= VID;
            vid_addr <= fb_base + ADDR_W'(offset);
          end else if (take_cpu) begin
            state <= CPU;
          end
        end
        VID: begin
          if (mem_ack) begin
            vid_data  <= mem_rdata;
            vid_valid <= 1'b1;
            state     <= DONE;
          end
        end
        CPU: begin
          if (mem_ack) begin
            cpu_rdata <= mem_rdata;
            cpu_ack   <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Self-checking bench for vid_mem_arbiter: behavioural memory responder, fetch-address model
// and randomized video/CPU traffic.
module tb_vid_mem_arbiter;
  localparam int AW = 24;
  localparam int FW = 96;  // short frame so the wrap point is reached in a few hundred cycles
`ifdef VIDARB_STARVE_GUARD_EN
  localparam int STARVE_VALIDS = 5;
`else
  localparam int STARVE_VALIDS = 7;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          vid_req, vid_frame, vid_valid;
  logic [31:0]   vid_data;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic [3:0]    cpu_be;
  logic          cfg_we, vid_ovr;
  logic [AW-1:0] cfg_wdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_be;

  int            errs = 0;
  int            checks = 0;
  int            cyc = 0;
  int            wait_cnt = 0;
  int            lat_max = 0;
  int            exp_off = 0;
  bit            ack_en = 1'b1;
  logic [AW-1:0] base = '0;

  vid_mem_arbiter #(.ADDR_W(AW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rstn(rstn),
    .vid_req(vid_req), .vid_frame(vid_frame), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .vid_ovr(vid_ovr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    return {a[7:0], a} ^ 32'hA5C3_1E00;
  endfunction

  function automatic logic [AW-1:0] vaddr();
    return base + AW'(exp_off);
  endfunction

  // One clock: clear one-cycle pulses, then play the memory side for the new cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    vid_req = 1'b0; vid_frame = 1'b0; cfg_we = 1'b0;
    cyc++;
    if (mem_req && ack_en && wait_cnt == 0) begin
      mem_ack = 1'b1; mem_rdata = memf(mem_addr);
    end else begin
      mem_ack = 1'b0; mem_rdata = $urandom();
      if (!mem_req) wait_cnt = $urandom_range(lat_max, 0);
      else if (ack_en) wait_cnt--;
    end
  endtask

  task automatic wait_mem(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (mem_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic fetch_vid(output logic [AW-1:0] a, output logic [31:0] d, output bit ok);
    a = '1; d = '0; ok = 1'b0;
    vid_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (mem_req && mem_ack) a = mem_addr;
      if (vid_valid) begin d = vid_data; ok = 1'b1; break; end
    end
  endtask

  task automatic restart();
    vid_frame = 1'b1;
    cycle();
    exp_off = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; vid_req = 0; vid_frame = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0;
    cpu_wdata = '0; cpu_be = '0; cfg_we = 0; cfg_wdata = '0; mem_ack = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req: got %0b want 0", mem_req); end
    checks++; if (vid_valid !== 1'b0) begin errs++; $display("FAIL rst_vid_valid: got %0b want 0", vid_valid); end
    checks++; if (cpu_ack !== 1'b0) begin errs++; $display("FAIL rst_cpu_ack: got %0b want 0", cpu_ack); end
    checks++; if (vid_ovr !== 1'b0) begin errs++; $display("FAIL rst_vid_ovr: got %0b want 0", vid_ovr); end
    checks++; if (vid_data !== 32'h0) begin errs++; $display("FAIL rst_vid_data: got %0h want 0", vid_data); end
    checks++; if (cpu_rdata !== 32'h0) begin errs++; $display("FAIL rst_cpu_rdata: got %0h want 0", cpu_rdata); end
    rstn = 1'b1;
    cycle();
    checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_idle_after: got %0b want 0", mem_req); end
  endtask

  task automatic test_latency();
    lat_max = 0; ack_en = 1'b1;
    cycle();
    vid_req = 1'b1;                      // cycle 0
    cycle();                             // cycle 1
    checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL lat_c1_mem_req: got %0b want 0", mem_req); end
    cycle();                             // cycle 2
    checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL lat_c2_mem_req: got %0b want 1", mem_req); end
    checks++; if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, 24'h0}) begin errs++;
      $display("FAIL lat_c2_port: got we=%0b be=%0h addr=%0h want we=0 be=f addr=0", mem_we, mem_be, mem_addr); end
    cycle();                             // cycle 3
    checks++; if (vid_valid !== 1'b1) begin errs++; $display("FAIL lat_c3_valid: got %0b want 1", vid_valid); end
    checks++; if (vid_data !== memf(24'h0)) begin errs++; $display("FAIL lat_c3_data: got %0h want %0h", vid_data, memf(24'h0)); end
    cycle();
    checks++; if (vid_valid !== 1'b0) begin errs++; $display("FAIL lat_c4_valid: got %0b want 0", vid_valid); end
    exp_off = 1;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a, want;
    logic [31:0]   d;
    bit            ok;
    lat_max = 2;
    base = 24'h010000;
    cfg_we = 1'b1; cfg_wdata = base; vid_frame = 1'b1;
    cycle();
    exp_off = 0;
    for (int k = 0; k <= FW; k++) begin
      fetch_vid(a, d, ok);
      want = vaddr();
      checks++; if (!ok) begin errs++; $display("FAIL wrap_timeout: fetch %0d got no vid_valid want one", k); end
      checks++; if (a !== want) begin errs++; $display("FAIL wrap_addr: fetch %0d got %0h want %0h", k, a, want); end
      checks++; if (d !== memf(want)) begin errs++; $display("FAIL wrap_data: fetch %0d got %0h want %0h", k, d, memf(want)); end
      if (k == FW - 1) begin
        checks++; if (a !== 24'h01005F) begin errs++; $display("FAIL wrap_last: got %0h want 01005f", a); end
      end
      if (k == FW) begin
        checks++; if (a !== 24'h010000) begin errs++; $display("FAIL wrap_next: got %0h want 010000", a); end
      end
      exp_off = (exp_off + 1) % FW;
    end
  endtask

  task automatic test_priority();
    bit ok;
    int vcnt, macc, ackc;
    logic [31:0] rd;
    for (int it = 0; it < 3; it++) begin
      restart();
      lat_max = 1; ack_en = 1'b0; vid_req = 1'b1;
      wait_mem(ok);
      checks++; if (!ok) begin errs++; $display("FAIL prio_stall: got no mem_req want mem_req"); end
      vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = {1'b1, 23'($urandom)};
      cpu_wdata = $urandom(); cpu_be = 4'($urandom);
      ack_en = 1'b1; vcnt = 0; macc = -10; ackc = -1; rd = '0;
      for (int i = 0; i < 40; i++) begin
        cycle();
        if (mem_req && mem_ack) begin
          if (mem_addr[23]) begin
            macc = cyc;
            checks++; if ({mem_we, mem_be, mem_wdata} !== {cpu_we, cpu_be, cpu_wdata}) begin errs++;
              $display("FAIL prio_cpu_port: got %0b/%0h/%0h want %0b/%0h/%0h", mem_we, mem_be, mem_wdata, cpu_we, cpu_be, cpu_wdata); end
          end else begin
            checks++; if (mem_addr !== vaddr()) begin errs++; $display("FAIL prio_vid_addr: got %0h want %0h", mem_addr, vaddr()); end
            exp_off = (exp_off + 1) % FW;
          end
        end
        if (vid_valid) vcnt++;
        if (cpu_ack) begin ackc = cyc; rd = cpu_rdata; cpu_req = 1'b0; break; end
      end
      checks++; if (ackc < 0) begin errs++; $display("FAIL prio_timeout: got no cpu_ack want cpu_ack"); end
      checks++; if (vcnt != 2) begin errs++; $display("FAIL prio_order: got %0d video words before cpu_ack want 2", vcnt); end
      checks++; if (ackc != macc + 1) begin errs++; $display("FAIL prio_ack_lat: got cycle %0d want %0d", ackc, macc + 1); end
      checks++; if (rd !== memf(cpu_addr)) begin errs++; $display("FAIL prio_rdata: got %0h want %0h", rd, memf(cpu_addr)); end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int vcnt;
    restart();
    lat_max = 0; ack_en = 1'b0; vid_req = 1'b1;
    wait_mem(ok);
    checks++; if (!ok) begin errs++; $display("FAIL ovr_stall: got no mem_req want mem_req"); end
    vid_req = 1'b1;
    cycle();
    checks++; if (vid_ovr !== 1'b0) begin errs++; $display("FAIL ovr_one_pending: got %0b want 0", vid_ovr); end
    vid_req = 1'b1;
    cycle();
    checks++; if (vid_ovr !== 1'b1) begin errs++; $display("FAIL ovr_set: got %0b want 1", vid_ovr); end
    vid_req = 1'b1; cfg_we = 1'b1; cfg_wdata = base;
    cycle();
    checks++; if (vid_ovr !== 1'b1) begin errs++; $display("FAIL ovr_set_wins: got %0b want 1", vid_ovr); end
    cfg_we = 1'b1; cfg_wdata = base;
    cycle();
    checks++; if (vid_ovr !== 1'b0) begin errs++; $display("FAIL ovr_cleared: got %0b want 0", vid_ovr); end
    ack_en = 1'b1; vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (mem_req && mem_ack) begin
        checks++; if (mem_addr !== vaddr()) begin errs++; $display("FAIL ovr_drain_addr: got %0h want %0h", mem_addr, vaddr()); end
        exp_off = (exp_off + 1) % FW;
      end
      if (vid_valid) vcnt++;
    end
    checks++; if (vcnt != 2) begin errs++; $display("FAIL ovr_drain_count: got %0d want 2", vcnt); end
  endtask

  task automatic test_frame();
    bit ok;
    int vcnt;
    logic [AW-1:0] infl, a;
    logic [31:0]   d;
    restart();
    lat_max = 0; ack_en = 1'b0;
    fetch_vid(a, d, ok);                 // stalls: no ack yet
    infl = mem_addr;
    vid_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = memf(infl); vid_frame = 1'b1;
    cycle();
    checks++; if (vid_valid !== 1'b1) begin errs++; $display("FAIL frame_inflight_valid: got %0b want 1", vid_valid); end
    checks++; if (vid_data !== memf(infl)) begin errs++; $display("FAIL frame_inflight_data: got %0h want %0h", vid_data, memf(infl)); end
    ack_en = 1'b1;
    fetch_vid(a, d, ok);
    checks++; if (a !== base) begin errs++; $display("FAIL frame_clear_wins: got %0h want %0h", a, base); end
    ack_en = 1'b0; vid_req = 1'b1;
    wait_mem(ok);
    vid_req = 1'b1;
    cycle();
    vid_frame = 1'b1;
    cycle();
    ack_en = 1'b1; vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (vid_valid) vcnt++;
    end
    checks++; if (vcnt != 1) begin errs++; $display("FAIL frame_pend_cleared: got %0d words want 1", vcnt); end
    restart();
    fetch_vid(a, d, ok);
    checks++; if (a !== base) begin errs++; $display("FAIL frame_restart: got %0h want %0h", a, base); end
    exp_off = 1;
  endtask

  task automatic test_starve();
    bit ok, got;
    int feeds, nvalid;
    restart();
    lat_max = 0; ack_en = 1'b0; vid_req = 1'b1;
    wait_mem(ok);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {1'b1, 23'($urandom)}; cpu_be = 4'hF;
    ack_en = 1'b1; feeds = 0; nvalid = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (vid_valid) begin
        nvalid++;
        if (feeds < 6) begin vid_req = 1'b1; feeds++; end
      end
      if (cpu_ack) begin got = 1'b1; cpu_req = 1'b0; break; end
    end
    checks++; if (!got) begin errs++; $display("FAIL starve_timeout: got no cpu_ack want cpu_ack"); end
    checks++; if (nvalid != STARVE_VALIDS) begin errs++;
      $display("FAIL starve_grant: got %0d video words before cpu_ack want %0d", nvalid, STARVE_VALIDS); end
    repeat (15) cycle();
  endtask

  task automatic test_random();
    logic [31:0] vq[$];
    logic [31:0] exp_d;
    int mode, want_v, nv;
    bit want_c, gotc;
    lat_max = 3; ack_en = 1'b1;
    base = {2'b00, 22'($urandom)};
    cfg_we = 1'b1; cfg_wdata = base;
    cycle();
    restart();
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(3, 0);
      if (mode == 3) begin
        base = {2'b00, 22'($urandom)};
        cfg_we = 1'b1; cfg_wdata = base;
        cycle();
        continue;
      end
      want_v = 0; want_c = 1'b0; nv = 0; gotc = 1'b0;
      if (mode != 1) begin vid_req = 1'b1; want_v = 1; end
      if (mode != 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = {1'b1, 23'($urandom)};
        cpu_wdata = $urandom(); cpu_be = 4'($urandom); want_c = 1'b1;
      end
      for (int c = 0; c < 40 && (nv < want_v || (want_c && !gotc)); c++) begin
        cycle();
        if (mem_req && mem_ack) begin
          if (mem_addr[23]) begin
            checks++; if ({mem_we, mem_be, mem_wdata, mem_addr} !== {cpu_we, cpu_be, cpu_wdata, cpu_addr}) begin errs++;
              $display("FAIL rnd_cpu_port: got %0b/%0h/%0h/%0h want %0b/%0h/%0h/%0h", mem_we, mem_be, mem_wdata, mem_addr,
                       cpu_we, cpu_be, cpu_wdata, cpu_addr); end
          end else begin
            checks++; if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, vaddr()}) begin errs++;
              $display("FAIL rnd_vid_port: got %0b/%0h/%0h want 0/f/%0h", mem_we, mem_be, mem_addr, vaddr()); end
            vq.push_back(memf(vaddr()));
            exp_off = (exp_off + 1) % FW;
          end
        end
        if (vid_valid) begin
          nv++;
          checks++;
          if (vq.size() == 0) begin errs++; $display("FAIL rnd_vid_data: got %0h want no word", vid_data); end
          else begin
            exp_d = vq.pop_front();
            if (vid_data !== exp_d) begin errs++; $display("FAIL rnd_vid_data: got %0h want %0h", vid_data, exp_d); end
          end
        end
        if (cpu_ack) begin
          gotc = 1'b1;
          checks++; if (cpu_rdata !== memf(cpu_addr)) begin errs++; $display("FAIL rnd_cpu_rdata: got %0h want %0h", cpu_rdata, memf(cpu_addr)); end
          cpu_req = 1'b0;
        end
      end
      checks++; if (nv != want_v || gotc != want_c) begin errs++;
        $display("FAIL rnd_complete: got vid=%0d cpu=%0b want vid=%0d cpu=%0b", nv, gotc, want_v, want_c); end
    end
    checks++; if (vid_ovr !== 1'b0) begin errs++; $display("FAIL rnd_no_ovr: got %0b want 0", vid_ovr); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int acks;
    logic [AW-1:0] a;
    logic [31:0]   d;
    lat_max = 0; ack_en = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = {1'b1, 23'($urandom)}; cpu_wdata = $urandom(); cpu_be = 4'hF;
    wait_mem(ok);
    checks++; if (!ok || mem_addr !== cpu_addr) begin errs++; $display("FAIL rstmid_cpu_state: got addr %0h want %0h", mem_addr, cpu_addr); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rstmid_async_mem_req: got %0b want 0", mem_req); end
    acks = 0;
    for (int i = 0; i < 3; i++) begin cycle(); if (cpu_ack) acks++; end
    rstn = 1'b1; cpu_req = 1'b0; ack_en = 1'b1;
    for (int i = 0; i < 6; i++) begin cycle(); if (cpu_ack) acks++; end
    checks++; if (acks != 0) begin errs++; $display("FAIL rstmid_no_ack: got %0d cpu_ack pulses want 0", acks); end
    checks++; if (cpu_rdata !== 32'h0) begin errs++; $display("FAIL rstmid_cpu_rdata: got %0h want 0", cpu_rdata); end
    checks++; if (vid_data !== 32'h0) begin errs++; $display("FAIL rstmid_vid_data: got %0h want 0", vid_data); end
    fetch_vid(a, d, ok);
    checks++; if (a !== 24'h0) begin errs++; $display("FAIL rstmid_base_offset: got %0h want 0", a); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_priority();
    test_overrun();
    test_frame();
    test_starve();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
